// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory bus arbiter.
// Imported by the arbiter top and its starvation counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  localparam logic [3:0] BYTEEN_WORD  = 4'b1111;
  localparam int         STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive DM grants while IF waits.
// Ports: clk, rst_n, if_req, if_gnt, dm_gnt in; force_if out.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_gnt,
  input  logic dm_gnt,
  output logic force_if
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT =
    STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] ONE =
    STARVE_CNT_W'(1);

  logic [STARVE_CNT_W-1:0] cnt;
  logic [STARVE_CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (!if_req || if_gnt) begin
      cnt_nxt = '0;
    end else if (dm_gnt && cnt != LIMIT) begin
      cnt_nxt = cnt + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign force_if = (cnt == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (IF, DM) arbiter onto a single-port 1-cycle-latency bus.
// Ports: i_clk/i_reset_n, IF req/resp, DM req/resp, o_mem_*/i_mem_read_data.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_if_req,
  input  logic [WIDTH-1:0] i_if_addr,
  input  logic             i_if_flush,
  output logic             o_if_gnt,
  output logic             o_if_rvalid,
  output logic [WIDTH-1:0] o_if_rdata,
  input  logic             i_dm_req,
  input  logic             i_dm_we,
  input  logic [WIDTH-1:0] i_dm_addr,
  input  logic [WIDTH-1:0] i_dm_wdata,
  input  logic [3:0]       i_dm_byteen,
  output logic             o_dm_gnt,
  output logic             o_dm_rvalid,
  output logic [WIDTH-1:0] o_dm_rdata,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_write_data,
  output logic [3:0]       o_mem_byteen,
  output logic             o_mem_read_en,
  output logic             o_mem_write_en,
  input  logic [WIDTH-1:0] i_mem_read_data
);

  owner_e rsp_owner;
  owner_e rsp_owner_nxt;
  logic   if_drop;
  logic   if_drop_nxt;
  logic   force_if;
  logic   if_gnt;
  logic   dm_gnt;

  // Grants are forced low while in reset so every output reads 0.
  assign if_gnt = i_reset_n && i_if_req &&
                  (!i_dm_req || force_if);
  assign dm_gnt = i_reset_n && i_dm_req && !if_gnt;

  assign o_if_gnt = if_gnt;
  assign o_dm_gnt = dm_gnt;

  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (i_clk),
    .rst_n   (i_reset_n),
    .if_req  (i_if_req),
    .if_gnt  (if_gnt),
    .dm_gnt  (dm_gnt),
    .force_if(force_if)
  );

  always_comb begin
    o_mem_addr       = '0;
    o_mem_write_data = '0;
    o_mem_byteen     = '0;
    o_mem_read_en    = 1'b0;
    o_mem_write_en   = 1'b0;
    unique case (1'b1)
      if_gnt: begin
        o_mem_addr    = i_if_addr;
        o_mem_byteen  = BYTEEN_WORD;
        o_mem_read_en = 1'b1;
      end
      dm_gnt: begin
        o_mem_addr       = i_dm_addr;
        o_mem_write_data = i_dm_wdata;
        o_mem_byteen     = i_dm_byteen;
        o_mem_read_en    = !i_dm_we;
        o_mem_write_en   = i_dm_we;
      end
      default: ;
    endcase
  end

  // Owner of the response in the next cycle; DM writes return nothing.
  always_comb begin
    rsp_owner_nxt = OWN_NONE;
    if_drop_nxt   = 1'b0;
    if (if_gnt) begin
      rsp_owner_nxt = OWN_IF;
      if_drop_nxt   = i_if_flush;
    end else if (dm_gnt && !i_dm_we) begin
      rsp_owner_nxt = OWN_DM;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rsp_owner <= OWN_NONE;
      if_drop   <= 1'b0;
    end else begin
      rsp_owner <= rsp_owner_nxt;
      if_drop   <= if_drop_nxt;
    end
  end

  // A flush in the response cycle also kills the returning IF word.
  assign o_if_rvalid = (rsp_owner == OWN_IF) &&
                       !if_drop && !i_if_flush;
  assign o_dm_rvalid = (rsp_owner == OWN_DM);

  assign o_if_rdata = o_if_rvalid ? i_mem_read_data : '0;
  assign o_dm_rdata = o_dm_rvalid ? i_mem_read_data : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized + directed bench for mem_bus_arbiter.
// Compares every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int W   = 32;
  localparam int LIM = 4;

  logic         clk = 1'b0;
  logic         i_reset_n;
  logic         i_if_req;
  logic [W-1:0] i_if_addr;
  logic         i_if_flush;
  logic         o_if_gnt;
  logic         o_if_rvalid;
  logic [W-1:0] o_if_rdata;
  logic         i_dm_req;
  logic         i_dm_we;
  logic [W-1:0] i_dm_addr;
  logic [W-1:0] i_dm_wdata;
  logic [3:0]   i_dm_byteen;
  logic         o_dm_gnt;
  logic         o_dm_rvalid;
  logic [W-1:0] o_dm_rdata;
  logic [W-1:0] o_mem_addr;
  logic [W-1:0] o_mem_write_data;
  logic [3:0]   o_mem_byteen;
  logic         o_mem_read_en;
  logic         o_mem_write_en;
  logic [W-1:0] i_mem_read_data;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .WIDTH       (W),
    .STARVE_LIMIT(LIM)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (i_reset_n),
    .i_if_req        (i_if_req),
    .i_if_addr       (i_if_addr),
    .i_if_flush      (i_if_flush),
    .o_if_gnt        (o_if_gnt),
    .o_if_rvalid     (o_if_rvalid),
    .o_if_rdata      (o_if_rdata),
    .i_dm_req        (i_dm_req),
    .i_dm_we         (i_dm_we),
    .i_dm_addr       (i_dm_addr),
    .i_dm_wdata      (i_dm_wdata),
    .i_dm_byteen     (i_dm_byteen),
    .o_dm_gnt        (o_dm_gnt),
    .o_dm_rvalid     (o_dm_rvalid),
    .o_dm_rdata      (o_dm_rdata),
    .o_mem_addr      (o_mem_addr),
    .o_mem_write_data(o_mem_write_data),
    .o_mem_byteen    (o_mem_byteen),
    .o_mem_read_en   (o_mem_read_en),
    .o_mem_write_en  (o_mem_write_en),
    .i_mem_read_data (i_mem_read_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents seen by reads.
  function automatic logic [W-1:0] mem_val(input logic [W-1:0] a);
    if (a == 32'h10) return 32'h0051_3093;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Reference model state.
  int           starve = 0;
  int           p_own  = 0;
  logic [W-1:0] p_addr = '0;
  bit           p_drop = 0;
  logic [W-1:0] rd_next = '0;
  bit           g_if, g_dm;
  int           wr_cnt = 0;

  task automatic model_reset();
    starve = 0;
    p_own  = 0;
    p_drop = 0;
  endtask

  task automatic cycle(input bit ifr, input logic [W-1:0] ifa,
                       input bit fl, input bit dmr, input bit we,
                       input logic [W-1:0] dma,
                       input logic [W-1:0] wd,
                       input logic [3:0] be);
    logic [W-1:0] ea, ewd;
    logic [3:0]   ebe;
    bit           ere, ewe, eiv, edv;
    @(negedge clk);
    i_if_req        = ifr;
    i_if_addr       = ifa;
    i_if_flush      = fl;
    i_dm_req        = dmr;
    i_dm_we         = we;
    i_dm_addr       = dma;
    i_dm_wdata      = wd;
    i_dm_byteen     = be;
    i_mem_read_data = rd_next;
    #1;
    g_if = ifr && (!dmr || starve == LIM);
    g_dm = dmr && !g_if;
    ea = '0; ewd = '0; ebe = '0; ere = 0; ewe = 0;
    if (g_if) begin
      ea = ifa; ebe = 4'hF; ere = 1;
    end else if (g_dm) begin
      ea = dma; ewd = wd; ebe = be; ere = !we; ewe = we;
    end
    chk("if_gnt", o_if_gnt, g_if);
    chk("dm_gnt", o_dm_gnt, g_dm);
    chk("mem_addr", o_mem_addr, ea);
    chk("mem_wdata", o_mem_write_data, ewd);
    chk("mem_byteen", o_mem_byteen, ebe);
    chk("mem_rd_en", o_mem_read_en, ere);
    chk("mem_wr_en", o_mem_write_en, ewe);
    eiv = (p_own == 1) && !p_drop && !fl;
    edv = (p_own == 2);
    chk("if_rvalid", o_if_rvalid, eiv);
    chk("dm_rvalid", o_dm_rvalid, edv);
    chk("if_rdata", o_if_rdata, eiv ? mem_val(p_addr) : '0);
    chk("dm_rdata", o_dm_rdata, edv ? mem_val(p_addr) : '0);
    rd_next = o_mem_read_en ? mem_val(o_mem_addr) : W'($urandom);
    if (o_mem_write_en) wr_cnt++;
    if (!ifr || g_if) starve = 0;
    else if (g_dm && starve < LIM) starve++;
    p_own  = g_if ? 1 : ((g_dm && !we) ? 2 : 0);
    p_addr = g_if ? ifa : dma;
    p_drop = g_if && fl;
  endtask

  task automatic idle();
    cycle(0, '0, 0, 0, 0, '0, '0, 4'h0);
  endtask

  bit           if_pend, dm_pend, dm_we_r, fl_r, if_done;
  logic [W-1:0] if_a, dm_a, dm_d;
  logic [3:0]   dm_b;
  int           nw;

  initial begin
    i_reset_n = 0;
    i_if_req = 1; i_if_addr = 32'h44; i_if_flush = 0;
    i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h88;
    i_dm_wdata = 32'h1; i_dm_byteen = 4'hF;
    i_mem_read_data = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_gnt", o_if_gnt, 0);
    chk("rst_dm_gnt", o_dm_gnt, 0);
    chk("rst_rd_en", o_mem_read_en, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_if_rvalid", o_if_rvalid, 0);
    chk("rst_dm_rdata", o_dm_rdata, 0);
    @(negedge clk);
    i_reset_n = 1;
    i_if_req = 0; i_dm_req = 0;
    model_reset();
    rd_next = 32'hCAFE_0001;

    // IF-only read
    cycle(1, 32'h10, 0, 0, 0, '0, '0, 4'h0);
    chk("t1_gnt", o_if_gnt, 1);
    chk("t1_rd_en", o_mem_read_en, 1);
    chk("t1_byteen", o_mem_byteen, 4'hF);
    idle();
    chk("t1_rvalid", o_if_rvalid, 1);
    chk("t1_rdata", o_if_rdata, 32'h0051_3093);

    // IF + DM together
    cycle(1, 32'h40, 0, 1, 0, 32'h100, '0, 4'hF);
    chk("t2_dm_gnt", o_dm_gnt, 1);
    chk("t2_if_gnt0", o_if_gnt, 0);
    cycle(1, 32'h40, 0, 0, 0, '0, '0, 4'h0);
    chk("t2_dm_rvalid", o_dm_rvalid, 1);
    chk("t2_if_gnt1", o_if_gnt, 1);
    idle();
    chk("t2_if_rvalid", o_if_rvalid, 1);

    // Starvation limit
    idle();
    wr_cnt = 0; nw = 0; if_done = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(!if_done, 32'h80, 0, 1, 1,
            32'h300 + 32'(nw * 4), 32'(nw), 4'hF);
      if (i == 4) chk("t3_if_gnt_c4", o_if_gnt, 1);
      if (i == 3) chk("t3_dm_gnt_c3", o_dm_gnt, 1);
      if (g_if) if_done = 1;
      if (g_dm) nw++;
    end
    chk("t3_wr_cnt", wr_cnt, 5);

    // Flush
    idle();
    cycle(1, 32'h20, 0, 0, 0, '0, '0, 4'h0);
    cycle(1, 32'h24, 1, 0, 0, '0, '0, 4'h0);
    chk("t4_rvalid", o_if_rvalid, 0);
    chk("t4_rdata", o_if_rdata, 0);
    chk("t4_new_gnt", o_if_gnt, 1);
    idle();

    // DM byte write
    cycle(0, '0, 0, 1, 1, 32'h203, 32'hAB00_0000, 4'b1000);
    chk("t5_gnt", o_dm_gnt, 1);
    chk("t5_wr_en", o_mem_write_en, 1);
    chk("t5_rd_en", o_mem_read_en, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t5_no_rvalid", o_dm_rvalid, 0);
    end

    // Reset mid-cycle after a DM read grant
    cycle(0, '0, 0, 1, 0, 32'h100, '0, 4'hF);
    @(negedge clk);
    i_if_req = 1; i_if_addr = 32'h8;
    i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h104;
    i_mem_read_data = rd_next;
    #1;
    chk("t6_pre_rvalid", o_dm_rvalid, 1);
    #2;
    i_reset_n = 0;
    #1;
    chk("t6_if_gnt", o_if_gnt, 0);
    chk("t6_dm_gnt", o_dm_gnt, 0);
    chk("t6_dm_rvalid", o_dm_rvalid, 0);
    chk("t6_dm_rdata", o_dm_rdata, 0);
    chk("t6_rd_en", o_mem_read_en, 0);
    chk("t6_addr", o_mem_addr, 0);
    chk("t6_byteen", o_mem_byteen, 0);
    @(posedge clk);
    @(negedge clk);
    i_reset_n = 1;
    i_if_req = 0; i_dm_req = 0;
    model_reset();
    rd_next = W'($urandom);
    idle();
    chk("t6_post_dm", o_dm_rvalid, 0);
    chk("t6_post_if", o_if_rvalid, 0);

    // Randomized traffic
    if_pend = 0; dm_pend = 0;
    for (int c = 0; c < 600; c++) begin
      if (!if_pend && $urandom_range(0, 9) < 6) begin
        if_pend = 1;
        if_a = W'($urandom_range(0, 255)) << 2;
      end
      if (!dm_pend && $urandom_range(0, 9) < 8) begin
        dm_pend = 1;
        dm_we_r = 1'($urandom_range(0, 1));
        dm_a = W'($urandom_range(0, 1023));
        dm_d = W'($urandom);
        dm_b = 4'($urandom_range(1, 15));
      end
      fl_r = ($urandom_range(0, 4) == 0);
      cycle(if_pend, if_a, fl_r, dm_pend, dm_we_r,
            dm_a, dm_d, dm_b);
      if (g_if) if_pend = 0;
      if (g_dm) dm_pend = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
